rv_axil_master_bridge: RTL
==========================

Name: rv_axil_master_bridge

Overview:
Converts the RV32I core's single-outstanding load/store request port into AXI4-Lite master transactions. It drives the S00_AXI slave of ddr3_interface_v1_0, sitting directly upstream of that slave, and replaces the VIP master used in bench-level bring-up. The core issues one word-sized request at a time. The block runs the AW/W/B or AR/R handshakes and returns a single-cycle response pulse carrying read data and an error flag.

Parameters:
ADDR_WIDTH, 32, width of the AXI address and the core request address.
DATA_WIDTH, 32, data width; fixed at 32 (the core is RV32I); other values are unsupported.

Ports:
ACLK  in  1  clock; all logic on its rising edge.
ARESET  in  1  synchronous, active-high reset.
req_valid  in  1  core request present.
req_ready  out  1  bridge can accept a request (IDLE only).
req_we  in  1  1 = store, 0 = load.
req_addr  in  ADDR_WIDTH  byte address.
req_wdata  in  32  store data.
req_wstrb  in  4  store byte enables.
resp_valid  out  1  one-cycle response pulse.
resp_rdata  out  32  load data; 0 for stores and errors.
resp_err  out  1  1 = SLVERR/DECERR, misaligned address, or bad response.
M_AXI_AWADDR  out  ADDR_WIDTH  write address.
M_AXI_AWPROT  out  3  constant 3'b000.
M_AXI_AWVALID  out  1  write address valid.
M_AXI_AWREADY  in  1  write address ready.
M_AXI_WDATA  out  32  write data.
M_AXI_WSTRB  out  4  write strobes.
M_AXI_WVALID  out  1  write data valid.
M_AXI_WREADY  in  1  write data ready.
M_AXI_BRESP  in  2  write response.
M_AXI_BVALID  in  1  write response valid.
M_AXI_BREADY  out  1  write response ready.
M_AXI_ARADDR  out  ADDR_WIDTH  read address.
M_AXI_ARPROT  out  3  constant 3'b000.
M_AXI_ARVALID  out  1  read address valid.
M_AXI_ARREADY  in  1  read address ready.
M_AXI_RDATA  in  32  read data.
M_AXI_RRESP  in  2  read response.
M_AXI_RVALID  in  1  read data valid.
M_AXI_RREADY  out  1  read data ready.

Behaviour:
- States: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP. All outputs are registered.
- Reset (any cycle, including mid-transaction): next edge enters IDLE.
  - All VALID/READY outputs, resp_valid and resp_err go to 0; resp_rdata goes to 0; address/data registers go to 0.
  - An aborted transaction produces no response.
- IDLE: req_ready = 1. Acceptance happens on req_valid & req_ready. On acceptance, req_addr, req_wdata and req_wstrb are latched; inputs are ignored until the next IDLE.
- Accept with req_addr[1:0] != 0: go to RESP with resp_err = 1. No bus transaction is issued.
- Accept store with req_wstrb == 0: go to RESP with resp_err = 0. No bus transaction is issued.
- Accept store (aligned, nonzero strobe): go to WR_ADDR_DATA.
  - AWVALID and WVALID rise together on the next cycle.
  - AWADDR = {addr[ADDR_WIDTH-1:2], 2'b00}.
  - Each VALID drops independently on its own handshake. AW-before-W, W-before-AW and simultaneous handshakes must all work.
  - When both handshakes are complete (same-cycle completion counts), go to WR_RESP with BREADY = 1.
  - On BVALID & BREADY: BREADY drops and the state goes to RESP. resp_err = BRESP[1].
- Accept load (aligned): go to RD_ADDR with ARVALID = 1 the next cycle.
  - On ARREADY: go to RD_DATA with RREADY = 1.
  - On RVALID & RREADY: capture data and go to RESP. resp_rdata = RRESP[1] ? 0 : RDATA; resp_err = RRESP[1].
- RESP: resp_valid = 1 for exactly one cycle, then IDLE. req_ready stays 0 during RESP, so no back-to-back acceptance.
- Minimum latency with zero-wait slave, acceptance at cycle N:
  - store: AW/W at N+1, B at N+2, resp_valid at N+3.
  - load: AR at N+1, R at N+2, resp_valid at N+3.
- No timeout. A hung slave holds the bridge in its wait state indefinitely.
- BVALID/RVALID arriving outside WR_RESP/RD_DATA is ignored (READY is low).
- The block never sees more than one outstanding transaction.

Test Plan:
- Stores 0x00000001..0x00000004 to 0x0, 0x4, 0x8, 0xC (wstrb 0xF), then loads from the same addresses: four resp_valid pulses with resp_rdata 0x1..0x4 and resp_err = 0. With a zero-wait slave, each response comes 3 cycles after acceptance.
- Store 0xDEADBEEF to 0x4 with the slave holding WREADY low for 5 cycles after AWREADY: AWVALID drops after 1 cycle, WVALID holds 6 cycles, exactly one B handshake, resp_err = 0.
- Load from 0x6: resp_valid with resp_err = 1 and resp_rdata = 0. AWVALID/ARVALID never assert.
- Slave returns BRESP = 2'b10 (SLVERR) for a store to 0x8: resp_err = 1. Slave returns RRESP = 2'b11 for a load: resp_err = 1, resp_rdata = 0.
- Store with wstrb = 0x0: response with resp_err = 0 and no AXI activity. A store with wstrb = 0x3 of 0x0000ABCD to 0xC gives WSTRB = 0x3 on the bus.
- Assert ARESET for 1 cycle while in WR_RESP: all VALID/READY outputs are 0 on the next edge, no resp_valid, req_ready = 1; a following load completes normally.

Source files
------------

// File: rtl/rv_axil_master_bridge.sv
// Bridges the RV32I core's single-outstanding load/store port onto an AXI4-Lite master.
// One request at a time; each transaction ends with a one-cycle resp_valid pulse.
module rv_axil_master_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]              M_AXI_AWPROT,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]              M_AXI_ARPROT,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY
);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP
  } state_t;

  state_t                    state, state_n;
  logic [ADDR_WIDTH-1:2]     addr_q, addr_n;
  logic [DATA_WIDTH-1:0]     wdata_n, rdata_n;
  logic [DATA_WIDTH/8-1:0]   wstrb_n;
  logic                      awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n;
  logic                      req_ready_n, resp_valid_n, resp_err_n;
  logic                      unused_resp_lsb;

  // Only bit 1 of xRESP distinguishes OKAY/EXOKAY from SLVERR/DECERR.
  assign unused_resp_lsb = M_AXI_BRESP[0] ^ M_AXI_RRESP[0];

  assign M_AXI_AWADDR = {addr_q, 2'b00};
  assign M_AXI_ARADDR = {addr_q, 2'b00};
  assign M_AXI_AWPROT = '0;
  assign M_AXI_ARPROT = '0;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state         <= IDLE;
      addr_q        <= '0;
      M_AXI_WDATA   <= '0;
      M_AXI_WSTRB   <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_err      <= 1'b0;
    end else begin
      state         <= state_n;
      addr_q        <= addr_n;
      M_AXI_WDATA   <= wdata_n;
      M_AXI_WSTRB   <= wstrb_n;
      M_AXI_AWVALID <= awvalid_n;
      M_AXI_WVALID  <= wvalid_n;
      M_AXI_BREADY  <= bready_n;
      M_AXI_ARVALID <= arvalid_n;
      M_AXI_RREADY  <= rready_n;
      req_ready     <= req_ready_n;
      resp_valid    <= resp_valid_n;
      resp_rdata    <= rdata_n;
      resp_err      <= resp_err_n;
    end
  end

  always_comb begin
    state_n      = state;
    addr_n       = addr_q;
    wdata_n      = M_AXI_WDATA;
    wstrb_n      = M_AXI_WSTRB;
    awvalid_n    = M_AXI_AWVALID;
    wvalid_n     = M_AXI_WVALID;
    bready_n     = M_AXI_BREADY;
    arvalid_n    = M_AXI_ARVALID;
    rready_n     = M_AXI_RREADY;
    req_ready_n  = req_ready;
    resp_valid_n = 1'b0;
    rdata_n      = resp_rdata;
    resp_err_n   = resp_err;

    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          addr_n      = req_addr[ADDR_WIDTH-1:2];
          wdata_n     = req_wdata;
          wstrb_n     = req_wstrb;
          req_ready_n = 1'b0;
          if (req_addr[1:0] != 2'b00) begin
            state_n      = RESP;
            resp_valid_n = 1'b1;
            resp_err_n   = 1'b1;
            rdata_n      = '0;
          end else if (req_we && (req_wstrb == '0)) begin
            state_n      = RESP;
            resp_valid_n = 1'b1;
            resp_err_n   = 1'b0;
            rdata_n      = '0;
          end else if (req_we) begin
            state_n   = WR_ADDR_DATA;
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
          end else begin
            state_n   = RD_ADDR;
            arvalid_n = 1'b1;
          end
        end
      end
      WR_ADDR_DATA: begin
        // Each channel retires on its own handshake; a channel already done counts as complete.
        if (M_AXI_AWREADY) awvalid_n = 1'b0;
        if (M_AXI_WREADY)  wvalid_n  = 1'b0;
        if ((!M_AXI_AWVALID || M_AXI_AWREADY) && (!M_AXI_WVALID || M_AXI_WREADY)) begin
          state_n  = WR_RESP;
          bready_n = 1'b1;
        end
      end
      WR_RESP: begin
        if (M_AXI_BVALID) begin
          state_n      = RESP;
          bready_n     = 1'b0;
          resp_valid_n = 1'b1;
          resp_err_n   = M_AXI_BRESP[1];
          rdata_n      = '0;
        end
      end
      RD_ADDR: begin
        if (M_AXI_ARREADY) begin
          state_n   = RD_DATA;
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
        end
      end
      RD_DATA: begin
        if (M_AXI_RVALID) begin
          state_n      = RESP;
          rready_n     = 1'b0;
          resp_valid_n = 1'b1;
          resp_err_n   = M_AXI_RRESP[1];
          rdata_n      = M_AXI_RRESP[1] ? '0 : M_AXI_RDATA;
        end
      end
      RESP: begin
        state_n     = IDLE;
        req_ready_n = 1'b1;
      end
      default: begin
        state_n     = IDLE;
        req_ready_n = 1'b1;
      end
    endcase
  end

endmodule
